// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: ROB tag, CDB lane packet and small index helpers.
// Pure declarations; no timing or flow control of its own.
package ooo_pkg;

  localparam int DEF_TAG_W  = 6;
  localparam int DEF_DATA_W = 32;

  typedef logic [DEF_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic                  valid;
    rob_tag_t              tag;
    logic [DEF_DATA_W-1:0] data;
  } cdb_pkt_t;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Writeback request / CDB broadcast bundle; master = functional-unit side, slave = arbiter.
// req_ready is a same-cycle response; CDB lanes are never backpressured.
interface cdb_arbiter_if
  import ooo_pkg::*;
#(
  parameter int N_FU   = 4,
  parameter int N_CDB  = 2,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [N_FU-1:0]                req_valid;
  logic [N_FU-1:0][TAG_W-1:0]     req_tag;
  logic [N_FU-1:0][DATA_W-1:0]    req_data;
  logic [N_FU-1:0]                req_ready;
  logic [N_CDB-1:0]               cdb_valid;
  logic [N_CDB-1:0][TAG_W-1:0]    cdb_tag;
  logic [N_CDB-1:0][DATA_W-1:0]   cdb_data;

  modport master (
    output req_valid, req_tag, req_data,
    input  req_ready, cdb_valid, cdb_tag, cdb_data
  );

  modport slave (
    input  req_valid, req_tag, req_data,
    output req_ready, cdb_valid, cdb_tag, cdb_data
  );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot grant per lane in scan order from ptr_i.
// Zero latency; no state, so backpressure is handled entirely by the caller.
module rr_picker #(
  parameter  int N_FU  = 4,
  parameter  int N_CDB = 2,
  localparam int PTR_W = $clog2(N_FU)
) (
  input  logic [N_FU-1:0]             req_i,
  input  logic [PTR_W-1:0]            ptr_i,
  output logic [N_CDB-1:0][N_FU-1:0]  gnt_o,
  output logic [N_FU-1:0]             rdy_o,
  output logic                        any_o,
  output logic [PTR_W-1:0]            last_o
);

  always_comb begin
    logic [N_FU-1:0]  avail;
    logic             found;
    logic [PTR_W-1:0] idx;
    gnt_o  = '0;
    rdy_o  = '0;
    any_o  = 1'b0;
    last_o = ptr_i;
    avail  = req_i;
    found  = 1'b0;
    idx    = '0;
    // Each lane takes the first still-available requester, so lane k gets the k-th in scan order.
    for (int l = 0; l < N_CDB; l++) begin
      found = 1'b0;
      for (int k = 0; k < N_FU; k++) begin
        idx = PTR_W'((int'(ptr_i) + k) % N_FU);
        if (!found && avail[idx]) begin
          found       = 1'b1;
          avail[idx]  = 1'b0;
          gnt_o[l][idx] = 1'b1;
          rdy_o[idx]  = 1'b1;
          any_o       = 1'b1;
          last_o      = idx;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: grants up to N_CDB of N_FU results per cycle, broadcast one cycle later; lanes never stall.
// Define CDB_ARB_STATS_EN to add saturating per-FU stall counters on output stall_cnt.
module cdb_arbiter
  import ooo_pkg::*;
#(
  parameter int N_FU   = 4,
  parameter int N_CDB  = 2,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  cdb_arbiter_if.slave            bus
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [N_FU-1:0][15:0]   stall_cnt
`endif
);

  localparam int PTR_W = $clog2(N_FU);

  logic [PTR_W-1:0]            ptr_q, ptr_d;
  cdb_pkt_t [N_CDB-1:0]        lane_q, lane_d;
  logic [N_FU-1:0]             req_eff;
  logic [N_FU-1:0]             rdy;
  logic [N_CDB-1:0][N_FU-1:0]  gnt;
  logic                        any_gnt;
  logic [PTR_W-1:0]            last_gnt;

  // Flush and reset both suppress every grant, which also freezes the pointer.
  assign req_eff = bus.req_valid & {N_FU{~(flush | rst)}};

  rr_picker #(.N_FU(N_FU), .N_CDB(N_CDB)) u_pick (
    .req_i  (req_eff),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt),
    .rdy_o  (rdy),
    .any_o  (any_gnt),
    .last_o (last_gnt)
  );

  assign bus.req_ready = rdy;

  always_comb begin
    ptr_d  = any_gnt ? PTR_W'(wrap_inc(int'(last_gnt), N_FU)) : ptr_q;
    lane_d = lane_q;
    for (int l = 0; l < N_CDB; l++) begin
      lane_d[l].valid = |gnt[l];
      // Idle lanes keep their last tag/data to avoid needless toggling on the broadcast wires.
      if (|gnt[l]) begin
        lane_d[l].tag  = '0;
        lane_d[l].data = '0;
        for (int i = 0; i < N_FU; i++) begin
          if (gnt[l][i]) begin
            lane_d[l].tag  = lane_d[l].tag  | rob_tag_t'(bus.req_tag[i]);
            lane_d[l].data = lane_d[l].data | DEF_DATA_W'(bus.req_data[i]);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      lane_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      lane_q <= lane_d;
    end
  end

  for (genvar l = 0; l < N_CDB; l++) begin : g_lane
    assign bus.cdb_valid[l] = lane_q[l].valid;
    assign bus.cdb_tag[l]   = TAG_W'(lane_q[l].tag);
    assign bus.cdb_data[l]  = DATA_W'(lane_q[l].data);
  end

`ifdef CDB_ARB_STATS_EN
  logic [N_FU-1:0][15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    for (int i = 0; i < N_FU; i++) begin
      if (!flush && bus.req_valid[i] && !rdy[i] && stall_q[i] != 16'hFFFF) begin
        stall_d[i] = stall_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
